dino_jump_ctrl: RTL and testbench

Vertical-motion stage for the dino, sitting directly beside the game-state FSM.
- Edge-detects the synchronised jump button and supplies the one-cycle jump pulse that the game-state FSM consumes.
- Consumes the FSM's 2-bit game state and runs the jump arc (rise, apex, fall, land) once per frame tick.
- Drives the dino height used by the renderer and collision logic.

---
 rtl/dino_jump_ctrl.sv | 128 ++++++++++++
 tb/tb_dino_jump_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dino_jump_ctrl.sv
// Dino vertical-motion stage: jump-button edge detect plus a per-frame
// rise/fall arc driven by the game-state FSM.
module dino_jump_ctrl #(
    parameter int Y_W     = 10,
    parameter int JUMP_V0 = 12,
    parameter int GRAVITY = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           frame_tick,
    input  logic           jump_btn,
    input  logic [1:0]     game_state,
    output logic           jump_pulse,
    output logic [Y_W-1:0] dino_y,
    output logic           airborne,
    output logic           landed
);

    typedef enum logic [1:0] {
        GS_INIT     = 2'b00,
        GS_DEAD     = 2'b01,
        GS_IN_GAME  = 2'b10,
        GS_INIT_ALT = 2'b11
    } game_state_t;

    typedef enum logic [1:0] {
        GROUND,
        RISING,
        FALLING
    } phase_t;

    localparam logic [Y_W-1:0] V0 = Y_W'(JUMP_V0);
    localparam logic [Y_W-1:0] G  = Y_W'(GRAVITY);

    phase_t        phase;
    game_state_t   gs;
    logic [Y_W-1:0] spd;
    logic          pending;
    logic          btn_prev;

    logic [Y_W-1:0] rise_d;
    logic [Y_W:0]   rise_sum;
    logic [Y_W:0]   fall_sum;
    logic [Y_W-1:0] fall_s;

    assign gs = game_state_t'(game_state);

    // Gravity is applied before displacement in both phases, so the default
    // arc climbs 12+11+..+1 = 78 and falls 1+2+..+12 back to ground.
    always_comb begin
        rise_d   = (spd > G) ? spd - G : '0;
        rise_sum = {1'b0, dino_y} + {1'b0, rise_d};
        fall_sum = {1'b0, spd} + {1'b0, G};
        fall_s   = (fall_sum > {1'b0, V0}) ? V0 : fall_sum[Y_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_prev   <= 1'b1;
            jump_pulse <= 1'b0;
            dino_y     <= '0;
            spd        <= '0;
            phase      <= GROUND;
            pending    <= 1'b0;
            airborne   <= 1'b0;
            landed     <= 1'b0;
        end else begin
            btn_prev   <= jump_btn;
            jump_pulse <= jump_btn & ~btn_prev;
            landed     <= 1'b0;
            case (gs)
                GS_IN_GAME: begin
                    if (frame_tick) begin
                        case (phase)
                            GROUND: begin
                                if (pending) begin
                                    phase    <= RISING;
                                    spd      <= V0;
                                    dino_y   <= V0;
                                    airborne <= 1'b1;
                                end
                            end
                            RISING: begin
                                dino_y <= rise_sum[Y_W] ? '1 : rise_sum[Y_W-1:0];
                                if (rise_d <= G) begin
                                    spd   <= '0;
                                    phase <= FALLING;
                                end else begin
                                    spd <= rise_d;
                                end
                            end
                            FALLING: begin
                                if (fall_s >= dino_y) begin
                                    dino_y   <= '0;
                                    spd      <= '0;
                                    phase    <= GROUND;
                                    airborne <= 1'b0;
                                    landed   <= 1'b1;
                                end else begin
                                    dino_y <= dino_y - fall_s;
                                    spd    <= fall_s;
                                end
                            end
                            default: phase <= GROUND;
                        endcase
                    end
                    // The registered pulse is the jump edge, so a press on the
                    // landing clk is seen once the dino is already grounded.
                    if (frame_tick && phase == GROUND && pending)
                        pending <= 1'b0;
                    else if (jump_pulse && phase == GROUND)
                        pending <= 1'b1;
                end
                GS_DEAD: begin
                    pending <= 1'b0;
                end
                default: begin
                    dino_y   <= '0;
                    spd      <= '0;
                    phase    <= GROUND;
                    pending  <= 1'b0;
                    airborne <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Bench for dino_jump_ctrl: a tick-count model of the default jump arc checked
// every cycle, plus literal expectations along the directed scenarios.
module tb_dino_jump_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       jump_btn = 1'b1;
    logic [1:0] game_state = 2'b00;
    logic       jump_pulse;
    logic [9:0] dino_y;
    logic       airborne;
    logic       landed;

    int n_checks = 0;
    int n_errors = 0;

    dino_jump_ctrl #(.Y_W(10), .JUMP_V0(12), .GRAVITY(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .jump_btn   (jump_btn),
        .game_state (game_state),
        .jump_pulse (jump_pulse),
        .dino_y     (dino_y),
        .airborne   (airborne),
        .landed     (landed)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: m_k counts frame ticks since take-off (0 = on ground); the
    // default arc lasts 24 ticks, height given in closed form.
    int m_k;
    bit m_pending, m_prev, m_pulse, m_landed;
    bit old_pulse, grounded, take;

    function automatic int exp_y(input int k);
        if (k == 0) return 0;
        if (k <= 12) return 12 * k - k * (k - 1) / 2;
        return 78 - (k - 12) * (k - 11) / 2;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_k = 0; m_pending = 0; m_prev = 1; m_pulse = 0; m_landed = 0;
        end else begin
            old_pulse = m_pulse;
            grounded  = (m_k == 0);
            take      = 0;
            m_landed  = 0;
            if (game_state == 2'b10) begin
                if (frame_tick) begin
                    if (grounded) begin
                        if (m_pending) begin m_k = 1; take = 1; end
                    end else begin
                        m_k++;
                        if (m_k == 24) begin m_k = 0; m_landed = 1; end
                    end
                end
                if (take) m_pending = 0;
                else if (old_pulse && grounded) m_pending = 1;
            end else if (game_state == 2'b01) begin
                m_pending = 0;
            end else begin
                m_k = 0; m_pending = 0;
            end
            m_pulse = jump_btn & ~m_prev;
            m_prev  = jump_btn;
        end
    end

    always @(negedge clk) begin
        check("jump_pulse", {31'd0, jump_pulse}, {31'd0, m_pulse});
        check("dino_y",     {22'd0, dino_y},     exp_y(m_k));
        check("airborne",   {31'd0, airborne},   {31'd0, (m_k != 0)});
        check("landed",     {31'd0, landed},     {31'd0, m_landed});
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
    endtask

    task automatic press();
        jump_btn = 1'b0;
        cyc(2);
        jump_btn = 1'b1;
        cyc(2);
    endtask

    initial begin
        // Reset with button held, then release reset with button still held
        cyc(3);
        check("rst_y", {22'd0, dino_y}, 0);
        check("rst_air", {31'd0, airborne}, 0);
        check("rst_pulse", {31'd0, jump_pulse}, 0);
        rst = 1'b1;
        cyc(3);
        check("held_no_pulse", {31'd0, jump_pulse}, 0);
        jump_btn = 1'b0;
        cyc(2);
        jump_btn = 1'b1;
        cyc(1);
        check("pulse_high", {31'd0, jump_pulse}, 1);
        cyc(1);
        check("pulse_one_clk", {31'd0, jump_pulse}, 0);
        check("init_y", {22'd0, dino_y}, 0);
        check("init_air", {31'd0, airborne}, 0);

        // Press in Init leaves nothing pending
        game_state = 2'b10;
        cyc(1);
        tick();
        check("init_no_pending", {22'd0, dino_y}, 0);

        // Full default arc
        press();
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (i == 1)  check("arc_t1", {22'd0, dino_y}, 12);
            if (i == 2)  check("arc_t2", {22'd0, dino_y}, 23);
            if (i == 12) check("arc_apex", {22'd0, dino_y}, 78);
            if (i == 13) check("arc_t13", {22'd0, dino_y}, 77);
            if (i == 23) check("arc_t23_air", {31'd0, airborne}, 1);
            if (i == 24) begin
                check("arc_land_y", {22'd0, dino_y}, 0);
                check("arc_land_pulse", {31'd0, landed}, 1);
                check("arc_land_air", {31'd0, airborne}, 0);
            end
            cyc(1);
        end

        // Press mid-air is ignored
        press();
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (i == 4) press();
            if (i == 24) check("midair_land", {31'd0, landed}, 1);
        end
        tick();
        tick();
        check("midair_no_buffer", {22'd0, dino_y}, 0);

        // Press on the landing clk, then frame tick coinciding with the pulse
        press();
        for (int i = 1; i <= 23; i++) begin
            tick();
            if (i == 20) jump_btn = 1'b0;
        end
        frame_tick = 1'b1;
        jump_btn   = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        check("land_press_landed", {31'd0, landed}, 1);
        tick();
        check("overlap_no_takeoff", {22'd0, dino_y}, 0);
        tick();
        check("overlap_takeoff", {22'd0, dino_y}, 12);
        for (int i = 2; i <= 6; i++) tick();
        check("rise_t6", {22'd0, dino_y}, 57);

        // Dead freezes, Init clears
        game_state = 2'b01;
        for (int i = 0; i < 10; i++) tick();
        check("dead_frozen", {22'd0, dino_y}, 57);
        check("dead_air", {31'd0, airborne}, 1);
        game_state = 2'b00;
        cyc(1);
        check("init_clear_y", {22'd0, dino_y}, 0);
        check("init_clear_air", {31'd0, airborne}, 0);

        // Async reset mid-fall
        game_state = 2'b10;
        press();
        for (int i = 1; i <= 20; i++) tick();
        check("fall_t20", {22'd0, dino_y}, 42);
        #2 rst = 1'b0;
        #1;
        check("async_y", {22'd0, dino_y}, 0);
        check("async_air", {31'd0, airborne}, 0);
        check("async_landed", {31'd0, landed}, 0);
        check("async_pulse", {31'd0, jump_pulse}, 0);
        cyc(2);
        rst = 1'b1;
        cyc(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
